mem_bridge: RTL

MEM_BRIDGE -- requirements
Module: mem_bridge

---
 rtl/mem_bridge.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mem_bridge.sv
// mem_bridge: links the multicycle control FSM to a handshaked external memory.
// Latches the address/data/control for each access, raises stall while the
// access is in flight, and captures read data into instr or mdr on ack.
// Optional feature macro: MEM_TIMEOUT_EN adds a BUSY-cycle watchdog that
// abandons an access after TIMEOUT_CYCLES cycles without ack and sets err.
module mem_bridge #(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              IorD,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              IRWrite,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_req,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] instr,
    output logic [5:0]        Op,
    output logic [DATA_W-1:0] mdr,
    output logic              stall,
    output logic              err
);

`ifdef MEM_TIMEOUT_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    // The watchdog fires in the BUSY cycle that would be the TIMEOUT_CYCLES-th.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     next_state;
    logic       ir_flag;
    logic [7:0] wd_count;
    logic       timeout;
    logic       start;

    assign Op      = instr[31:26];
    assign timeout = WD_EN && (wd_count == TIMEOUT_LAST);

    // State register; reset abandons any in-flight access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state selection and the combinational stall to the control FSM.
    always_comb begin
        next_state = state;
        stall      = 1'b0;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (MemRead || MemWrite) begin
                    start      = 1'b1;
                    stall      = 1'b1;
                    next_state = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (mem_ack || timeout) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Request latching, read-data capture, watchdog count and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            instr     <= '0;
            mdr       <= '0;
            err       <= 1'b0;
            ir_flag   <= 1'b0;
            wd_count  <= '0;
        end else if (start) begin
            mem_addr  <= IorD ? alu_out : pc;
            mem_wdata <= wdata;
            mem_we    <= MemWrite;
            ir_flag   <= IRWrite;
            mem_req   <= 1'b1;
            wd_count  <= '0;
            if (MemRead && MemWrite) begin
                err <= 1'b1;
            end
        end else if (state == BUSY) begin
            if (mem_ack) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
                if (!mem_we) begin
                    if (ir_flag) begin
                        instr <= mem_rdata;
                    end else begin
                        mdr <= mem_rdata;
                    end
                end
            end else if (timeout) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
                err     <= 1'b1;
            end else if (WD_EN) begin
                wd_count <= wd_count + 8'd1;
            end
        end
    end

endmodule
